// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the rr_arbiter4 round-robin arbiter.
package rr_arbiter4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ = 4;

  // Rotate right by the pointer so bit 0 of the result is the highest-priority request.
  function automatic logic [NUM_REQ-1:0] rotate_by_ptr(input logic [NUM_REQ-1:0] v,
                                                       input logic [1:0]         ptr);
    logic [2*NUM_REQ-1:0] doubled;
    doubled = {v, v} >> ptr;
    return doubled[NUM_REQ-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter4_encoder2to4.sv
// One-hot to binary encoder: turns the registered grant vector into its 2-bit index.
module encoder2to4 (
  input  logic [3:0] onehot,
  output logic [1:0] idx
);

  // All-zero input encodes to 0, matching the idle index.
  assign idx[0] = onehot[1] | onehot[3];
  assign idx[1] = onehot[2] | onehot[3];

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and encoded index.
// Optional hold limit enabled by defining RR_ARBITER4_HOLD_LIMIT_EN.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  output logic [3:0]   grant,
  output logic [1:0]   gidx,
  output logic         valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be in 2..256");
  end

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_d;
  logic [1:0]            ptr_q, ptr_d;

  logic [NUM_REQ-1:0]    cand;
  logic [NUM_REQ-1:0]    cand_rot;
  logic [1:0]            win_off;
  logic [1:0]            win_idx;
  logic                  win_found;
  logic                  owner_held;
  logic                  force_rotate;

`ifdef RR_ARBITER4_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0]            cnt_q, cnt_d;
`endif

  // The owner is excluded from the candidate set: it only loses the resource when it
  // drops its request or is forced out, and in both cases it must not win again.
  assign cand       = req & ~grant;
  assign owner_held = |(req & grant);
  assign win_found  = |cand;
  assign win_idx    = ptr_q + win_off;

  always_comb begin
    cand_rot = rotate_by_ptr(cand, ptr_q);
    win_off  = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_rot[i]) win_off = 2'(i);
    end
  end

`ifdef RR_ARBITER4_HOLD_LIMIT_EN
  assign force_rotate = (cnt_q == HOLD_LAST) && win_found;
`else
  assign force_rotate = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    state_d = state_q;
    grant_d = grant;
    ptr_d   = ptr_q;
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          grant_d = 4'b0001 << win_idx;
          ptr_d   = win_idx + 2'd1;
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (owner_held && !force_rotate) begin
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
          if (cnt_q != HOLD_LAST) cnt_d = cnt_q + 8'd1;
`endif
        end else if (win_found) begin
          grant_d = 4'b0001 << win_idx;
          ptr_d   = win_idx + 2'd1;
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant   <= '0;
      ptr_q   <= 2'd0;
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  encoder2to4 u_enc (
    .onehot (grant),
    .idx    (gidx)
  );

  assign valid = |grant;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: vector table plus hold-limit sequences.
// Hold-limit expectations follow RR_ARBITER4_HOLD_LIMIT_EN as the DUT is built.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 4;
  localparam int NVEC     = 19;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       valid;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .gidx  (gidx),
    .valid (valid)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] gidx;
    logic       valid;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] gidx;
    logic       valid;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[NVEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] ei, input logic ev, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    sb.push_back('{eg, ei, ev, tag});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".grant"}, grant, e.grant);
      check({e.tag, ".gidx"},  {2'b00, gidx}, {2'b00, e.gidx});
      check({e.tag, ".valid"}, {3'b000, valid}, {3'b000, e.valid});
    end
  endtask

  task automatic step_g(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                        input string tag);
    step(r, rq, eg, enc(eg), |eg, tag);
  endtask

  initial begin
    logic [3:0] exp_g;

    rst = 1'b1;
    req = 4'b0000;

    // Reset, single request, idle.
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    // Fairness: all request, owner drops for one sample each grant.
    vecs[4]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
    vecs[6]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
    vecs[8]  = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
    vecs[9]  = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
    // Handover from owner 1 to 3 with no dead cycle.
    vecs[10] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[11] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[12] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[13] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
    // Reset mid-grant, pointer back to 0.
    vecs[14] = '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0};
    vecs[15] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[16] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    // Simultaneous requests with pointer at 2: wrap to requester 0.
    vecs[17] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
    vecs[18] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].grant, vecs[i].gidx, vecs[i].valid,
           $sformatf("vec%0d", i));
    end

    // Two requesters held constantly from idle.
    step_g(1'b1, 4'b0000, 4'b0000, "hold_rst");
    for (int k = 0; k < 17; k++) begin
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
      exp_g = ((k / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      step_g(1'b0, 4'b0011, exp_g, $sformatf("hold2_c%0d", k));
    end

    // Sole requester never loses the grant; saturated counter then yields at once.
    step_g(1'b1, 4'b0000, 4'b0000, "sole_rst");
    for (int k = 0; k < 20; k++) begin
      step_g(1'b0, 4'b0100, 4'b0100, $sformatf("sole_c%0d", k));
    end
`ifdef RR_ARBITER4_HOLD_LIMIT_EN
    step_g(1'b0, 4'b0101, 4'b0001, "sat_yield");
`else
    step_g(1'b0, 4'b0101, 4'b0100, "sat_yield");
`endif
    step_g(1'b0, 4'b0000, 4'b0000, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
